core_mul_iter: RTL and testbench
================================

Name: core_mul_iter

Overview:
- Iterative radix-2 shift-add multiplier front end. It is the producer side of the multiply-result interface consumed by the core's multiply output stage.
- Accepts raw RV64M operands and the opcode class, and records the operand sign flags.
- Multiplies operand magnitudes unsigned, one bit per cycle.
- Presents the 2*XLEN unsigned magnitude product, the sign flags and the passthrough control/isword fields, so the output stage can apply the two's-complement sign fix-up.

Parameters:
- XLEN, 64, operand width. Must be even and at least 8.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  synchronous active-low reset
- i_mul_iter_valid  in  1  request valid
- o_mul_iter_ready  out  1  block can accept a request
- i_mul_iter_srcA  in  XLEN  operand A (rs1)
- i_mul_iter_srcB  in  XLEN  operand B (rs2)
- i_mul_iter_control  in  2  00 MUL/MULW, 01 MULH, 10 MULHSU, 11 MULHU
- i_mul_iter_isword  in  1  word (W-suffix) operation
- i_mul_iter_flush  in  1  abort current operation (pipeline flush)
- o_mul_iter_valid  out  1  result valid
- i_mul_iter_ready  in  1  downstream accepts result
- o_mul_iter_product  out  2*XLEN  unsigned product of magnitudes
- o_mul_iter_srcA_Dsign  out  1  A treated as negative, doubleword op
- o_mul_iter_srcB_Dsign  out  1  B treated as negative, doubleword op
- o_mul_iter_srcA_Wsign  out  1  A[XLEN/2-1] negative, word op
- o_mul_iter_srcB_Wsign  out  1  B[XLEN/2-1] negative, word op
- o_mul_iter_control  out  2  registered control
- o_mul_iter_isword  out  1  registered isword

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is synchronous, active-low.
- Reset values:
  - state IDLE.
  - o_mul_iter_valid=0.
  - All registered outputs 0 (product, four sign flags, control, isword).
  - o_mul_iter_ready = (state==IDLE) & i_rst_n, so it is 0 while reset is asserted.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Ready is high.
  - On i_mul_iter_valid & o_mul_iter_ready, capture sign flags, control, isword and magnitudes; set count=N; go to CALC.
  - N = XLEN for doubleword ops, XLEN/2 for word ops.
- Sign and magnitude rules when not isword:
  - Asign = srcA[XLEN-1] for MUL, MULH and MULHSU; 0 for MULHU.
  - Bsign = srcB[XLEN-1] for MUL and MULH; 0 for MULHSU and MULHU.
  - Dsign outputs = Asign/Bsign; Wsign outputs = 0.
  - Magnitude = two's-complement negation of the operand if its sign flag is 1, else the operand. Magnitude of the most negative value is 2^(XLEN-1), which is representable unsigned.
- Sign and magnitude rules when isword:
  - Only the low XLEN/2 bits are used, treated as signed for every control value.
  - Wsign = bit XLEN/2-1 of each operand; Dsign outputs = 0.
  - Magnitudes are XLEN/2 wide, zero-extended.
- CALC (one bit per cycle):
  - Accumulator P[2*XLEN:0], with one carry bit; the low half is initialised to the multiplier magnitude (|B|) and the high half to 0.
  - Each cycle: if P[0]=1, add the multiplicand magnitude (|A|) into the high half, then logical shift right by 1 (carry enters the MSB). Decrement count.
  - When count reaches 1 and that final step completes, go to DONE.
- Product alignment:
  - Word ops: the product lands in bits [XLEN-1:0]; upper bits are 0.
  - Doubleword ops: full 2*XLEN product.
- Latency:
  - Request accepted at cycle T.
  - o_mul_iter_valid high from cycle T+N+1: T+65 for doubleword, T+33 for word at XLEN=64.
  - Fixed; there is no early-out for zero operands.
- DONE:
  - o_mul_iter_valid=1; product, flags, control and isword are held stable.
  - On i_mul_iter_ready, go to IDLE at the next edge; valid drops and ready rises.
  - Ready is low in CALC and DONE, so there is no overlap of operations.
  - Minimum throughput is one operation per N+2 cycles.
- Flush:
  - i_mul_iter_flush in any state forces IDLE at the next edge and clears valid.
  - Flush has priority over acceptance and completion.
  - Flush in IDLE together with valid does not accept the request.
- Reset mid-operation: same effect as flush, plus all outputs return to their reset values.
- Inputs in CALC/DONE are ignored; a request presented while ready=0 is not accepted.
- Output contract: the downstream negation rule (XOR of signs for MUL/MULH/MULW, A sign for MULHSU, none for MULHU) must yield the exact RV64M result.

Test Plan:
- MUL, A=0xFFFF_FFFF_FFFF_FFFD (-3), B=5, downstream ready=1 -> at T+65: product=15, srcA_Dsign=1, srcB_Dsign=0, Wsign=0; valid for 1 cycle. Downstream output stage yields 0xFFFF_FFFF_FFFF_FFF1.
- MULHU, A=B=0xFFFF_FFFF_FFFF_FFFF -> product=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, both Dsign=0.
- MULHSU, A=-1, B=0x8000_0000_0000_0000 -> srcA_Dsign=1, srcB_Dsign=0, product=0x0000_0000_0000_0000_8000_0000_0000_0000. Downstream high half = 0xFFFF_FFFF_FFFF_FFFF.
- MULW, A=0x0000_0000_8000_0000, B=2 -> valid at T+33, srcA_Wsign=1, srcB_Wsign=0, Dsign=0, product=0x1_0000_0000.
- Backpressure: hold i_mul_iter_ready=0 for 10 cycles in DONE while driving a new valid request -> valid, product and flags stable, ready=0, new request not accepted. Release -> IDLE the next cycle, and the next request is accepted correctly.
- Flush at T+20 mid-CALC, then separately i_rst_n=0 at T+20 -> next cycle state IDLE, valid=0, ready=1 (flush case only). Following MUL 7*6 returns product=42.

Source files
------------

// File: rtl/core_mul_iter.sv
// Iterative radix-2 shift-add multiplier front end: multiplies operand magnitudes one bit
// per cycle and hands the unsigned product plus sign flags to the multiply output stage.
module core_mul_iter #(
  parameter int unsigned XLEN = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mul_iter_valid,
  output logic              o_mul_iter_ready,
  input  logic [XLEN-1:0]   i_mul_iter_srcA,
  input  logic [XLEN-1:0]   i_mul_iter_srcB,
  input  logic [1:0]        i_mul_iter_control,
  input  logic              i_mul_iter_isword,
  input  logic              i_mul_iter_flush,
  output logic              o_mul_iter_valid,
  input  logic              i_mul_iter_ready,
  output logic [2*XLEN-1:0] o_mul_iter_product,
  output logic              o_mul_iter_srcA_Dsign,
  output logic              o_mul_iter_srcB_Dsign,
  output logic              o_mul_iter_srcA_Wsign,
  output logic              o_mul_iter_srcB_Wsign,
  output logic [1:0]        o_mul_iter_control,
  output logic              o_mul_iter_isword
);

  localparam int unsigned Half = XLEN / 2;
  localparam int unsigned CntW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     mcand_q;
  logic [CntW-1:0]     count_q;

  logic                a_dsign, b_dsign, a_wsign, b_wsign;
  logic [Half-1:0]     a_lo_mag, b_lo_mag;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       acc_hi_sum;
  logic [2*XLEN-1:0]   acc_next;
  logic [2*XLEN-1:0]   done_prod;

  assign o_mul_iter_ready = (state_q == StIdle) & i_rst_n;

  // Operand sign decode and magnitude formation for the incoming request.
  always_comb begin
    a_dsign  = 1'b0;
    b_dsign  = 1'b0;
    a_wsign  = 1'b0;
    b_wsign  = 1'b0;
    a_lo_mag = '0;
    b_lo_mag = '0;
    a_mag    = '0;
    b_mag    = '0;
    if (i_mul_iter_isword) begin
      a_wsign  = i_mul_iter_srcA[Half-1];
      b_wsign  = i_mul_iter_srcB[Half-1];
      a_lo_mag = a_wsign ? ('0 - i_mul_iter_srcA[Half-1:0]) : i_mul_iter_srcA[Half-1:0];
      b_lo_mag = b_wsign ? ('0 - i_mul_iter_srcB[Half-1:0]) : i_mul_iter_srcB[Half-1:0];
      a_mag    = {{(XLEN-Half){1'b0}}, a_lo_mag};
      b_mag    = {{(XLEN-Half){1'b0}}, b_lo_mag};
    end else begin
      a_dsign = (i_mul_iter_control != 2'b11) & i_mul_iter_srcA[XLEN-1];
      b_dsign = ~i_mul_iter_control[1] & i_mul_iter_srcB[XLEN-1];
      a_mag   = a_dsign ? ('0 - i_mul_iter_srcA) : i_mul_iter_srcA;
      b_mag   = b_dsign ? ('0 - i_mul_iter_srcB) : i_mul_iter_srcB;
    end
  end

  // One shift-add step; the carry out of the high half shifts into the MSB.
  always_comb begin
    acc_hi_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_next   = {acc_hi_sum, acc_q[XLEN-1:1]};
    // Word ops run only Half steps, so the product still sits Half bits up.
    done_prod  = o_mul_iter_isword ? {{XLEN{1'b0}}, acc_next[XLEN+Half-1:Half]} : acc_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q               <= StIdle;
      acc_q                 <= '0;
      mcand_q               <= '0;
      count_q               <= '0;
      o_mul_iter_valid      <= 1'b0;
      o_mul_iter_product    <= '0;
      o_mul_iter_srcA_Dsign <= 1'b0;
      o_mul_iter_srcB_Dsign <= 1'b0;
      o_mul_iter_srcA_Wsign <= 1'b0;
      o_mul_iter_srcB_Wsign <= 1'b0;
      o_mul_iter_control    <= 2'b00;
      o_mul_iter_isword     <= 1'b0;
    end else if (i_mul_iter_flush) begin
      state_q          <= StIdle;
      o_mul_iter_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_mul_iter_valid) begin
            o_mul_iter_srcA_Dsign <= a_dsign;
            o_mul_iter_srcB_Dsign <= b_dsign;
            o_mul_iter_srcA_Wsign <= a_wsign;
            o_mul_iter_srcB_Wsign <= b_wsign;
            o_mul_iter_control    <= i_mul_iter_control;
            o_mul_iter_isword     <= i_mul_iter_isword;
            mcand_q               <= a_mag;
            acc_q                 <= {{XLEN{1'b0}}, b_mag};
            count_q               <= i_mul_iter_isword ? CntW'(Half) : CntW'(XLEN);
            state_q               <= StCalc;
          end
        end
        StCalc: begin
          acc_q   <= acc_next;
          count_q <= count_q - CntW'(1);
          if (count_q == CntW'(1)) begin
            o_mul_iter_product <= done_prod;
            o_mul_iter_valid   <= 1'b1;
            state_q            <= StDone;
          end
        end
        StDone: begin
          if (i_mul_iter_ready) begin
            o_mul_iter_valid <= 1'b0;
            state_q          <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mul_iter.sv
// Directed self-checking bench for core_mul_iter at XLEN=64.
module tb_core_mul_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  src_a = '0;
  logic [63:0]  src_b = '0;
  logic [1:0]   ctrl = 2'b00;
  logic         isw = 1'b0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         ds_ready = 1'b1;
  logic [127:0] product;
  logic         a_dsign, b_dsign, a_wsign, b_wsign;
  logic [1:0]   out_ctrl;
  logic         out_isw;

  int checks = 0;
  int errors = 0;

  core_mul_iter #(.XLEN(64)) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_mul_iter_valid      (in_valid),
    .o_mul_iter_ready      (in_ready),
    .i_mul_iter_srcA       (src_a),
    .i_mul_iter_srcB       (src_b),
    .i_mul_iter_control    (ctrl),
    .i_mul_iter_isword     (isw),
    .i_mul_iter_flush      (flush),
    .o_mul_iter_valid      (out_valid),
    .i_mul_iter_ready      (ds_ready),
    .o_mul_iter_product    (product),
    .o_mul_iter_srcA_Dsign (a_dsign),
    .o_mul_iter_srcB_Dsign (b_dsign),
    .o_mul_iter_srcA_Wsign (a_wsign),
    .o_mul_iter_srcB_Wsign (b_wsign),
    .o_mul_iter_control    (out_ctrl),
    .o_mul_iter_isword     (out_isw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for the result and check latency, product and flags.
  // flags = {srcA_Dsign, srcB_Dsign, srcA_Wsign, srcB_Wsign}
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] c, input logic w, input logic [127:0] exp_p,
                       input logic [3:0] exp_flags, input int exp_lat);
    int lat;
    lat = 0;
    src_a    = a;
    src_b    = b;
    ctrl     = c;
    isw      = w;
    in_valid = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 1) chk({tag, "_busy"}, {127'd0, in_ready}, 128'd0);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_prod"}, product, exp_p);
    chk({tag, "_flags"}, {124'd0, a_dsign, b_dsign, a_wsign, b_wsign}, {124'd0, exp_flags});
    chk({tag, "_ctl"}, {125'd0, out_ctrl, out_isw}, {125'd0, c, w});
    if (ds_ready) begin
      @(negedge clk);
      chk({tag, "_drop"}, {126'd0, out_valid, in_ready}, 128'b01);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_prod", product, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {127'd0, in_ready}, 128'd1);

    do_op("mul_neg3x5", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 2'b00, 1'b0, 128'd15, 4'b1000, 65);
    do_op("mulhu_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 4'b0000, 65);
    do_op("mulhsu", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b10, 1'b0,
          128'h0000_0000_0000_0000_8000_0000_0000_0000, 4'b1000, 65);
    do_op("mulw", 64'h0000_0000_8000_0000, 64'd2, 2'b00, 1'b1, 128'h1_0000_0000, 4'b0010, 33);
    do_op("mulh_negneg", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 2'b01, 1'b0,
          128'd6, 4'b1100, 65);
    // Word op ignores upper bits and treats low half as signed even with control=11
    do_op("mulw_garbage", 64'hDEAD_BEEF_0000_0003, 64'h1234_5678_FFFF_FFFE, 2'b11, 1'b1,
          128'd6, 4'b0001, 33);
    do_op("mul_minneg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 1'b0,
          128'h4000_0000_0000_0000_0000_0000_0000_0000, 4'b1100, 65);

    // Backpressure in DONE with a competing request
    ds_ready = 1'b0;
    do_op("bp", 64'd7, 64'd6, 2'b00, 1'b0, 128'd42, 4'b0000, 65);
    for (int i = 0; i < 10; i++) begin
      src_a    = 64'd9;
      src_b    = 64'hFFFF_FFFF_FFFF_FFFF;
      ctrl     = 2'b01;
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, a_dsign, b_dsign, out_ctrl, product[121:0]},
          {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 122'd42});
    end
    in_valid = 1'b0;
    ds_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {126'd0, out_valid, in_ready}, 128'b01);
    do_op("after_bp", 64'd1000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 128'd1000, 4'b0100, 65);

    // Flush mid-CALC
    src_a = 64'd3; src_b = 64'd4; ctrl = 2'b00; isw = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_state", {126'd0, out_valid, in_ready}, 128'b01);
    // Flush together with valid in IDLE must not accept
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_noaccept", {126'd0, out_valid, in_ready}, 128'b01);

    // Reset mid-CALC after a nonzero control was captured
    src_a = 64'd3; src_b = 64'd4; ctrl = 2'b01;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_hs", {126'd0, out_valid, in_ready}, 128'b00);
    chk("rst_mid_prod", product, 128'd0);
    chk("rst_mid_regs", {122'd0, a_dsign, b_dsign, a_wsign, b_wsign, out_ctrl},
        128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("mul_7x6", 64'd7, 64'd6, 2'b00, 1'b0, 128'd42, 4'b0000, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
